// File: rtl/sipo_framer.sv
// Serial-in/parallel-out framer: assembles 1..WIDTH bit frames MSB- or LSB-first
// into a double-buffered holding register presented on a valid/ready handshake.
module sipo_framer #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             serial_in,
  input  logic [CW-1:0]    frame_len,
  input  logic             lsb_first,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  output logic             busy,
  output logic [CW-1:0]    bit_count
);

  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    len_q;
  logic             lsb_q;

  logic [CW-1:0]    cur_len;
  logic             cur_lsb;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] frame_val;
  logic             accept;
  logic             complete;

  function automatic logic [CW-1:0] sanitise_len(input logic [CW-1:0] len);
    if (len == '0 || len > CW'(WIDTH)) return CW'(WIDTH);
    return len;
  endfunction

  function automatic logic [WIDTH-1:0] len_mask(input logic [CW-1:0] len);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (CW'(i) < len) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Shift stage: the first bit of a frame uses the live length/mode inputs,
  // later bits use the values latched at frame start.
  always_comb begin
    accept     = shift_en & ~clear;
    cur_len    = (bit_count == '0) ? sanitise_len(frame_len) : len_q;
    cur_lsb    = (bit_count == '0) ? lsb_first : lsb_q;
    shift_next = shift_reg;
    if (cur_lsb) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bit_count == CW'(i)) shift_next[i] = serial_in;
      end
    end else begin
      shift_next = {shift_reg[WIDTH-2:0], serial_in};
    end
    complete  = accept && ((bit_count + CW'(1)) == cur_len);
    frame_val = shift_next & len_mask(cur_len);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_count  <= '0;
      len_q      <= CW'(WIDTH);
      lsb_q      <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else if (clear) begin
      shift_reg  <= '0;
      bit_count  <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) begin
        if (bit_count == '0) begin
          len_q <= cur_len;
          lsb_q <= cur_lsb;
        end
        if (complete) begin
          shift_reg <= '0;
          bit_count <= '0;
        end else begin
          shift_reg <= shift_next;
          bit_count <= bit_count + CW'(1);
        end
      end
      // Output stage: a completed frame is dropped only if the held one is not leaving.
      if (complete) begin
        if (!data_valid || data_ready) begin
          data_out   <= frame_val;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

  assign busy = (bit_count != '0);

endmodule

// File: doc/sipo_framer.md
Name: sipo_framer

Overview:
Parametrised serial-in/parallel-out deserialiser for the UART receive path and other bit-serial peripherals. It accepts one bit per shift-enable strobe and assembles frames of programmable length (1..WIDTH) in MSB-first or LSB-first order. Completed frames go to a holding register and are presented on a valid/ready handshake, with overrun detection. The shift stage is double-buffered against the output stage, so the next frame can be assembled while the consumer drains the previous one.

Parameters:
WIDTH, 8, maximum frame length and data_out width; legal range >= 2
CW, $clog2(WIDTH+1), width of frame_len and bit_count; derived, do not override

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
clear  input  1  synchronous flush: aborts the partial frame, drops held data, clears overrun
shift_en  input  1  bit strobe; serial_in is sampled on a rising clk edge where shift_en=1
serial_in  input  1  serial data bit
frame_len  input  CW  bits per frame; 0 or >WIDTH is treated as WIDTH
lsb_first  input  1  1: first bit received lands in data_out[0]; 0: first bit is the MSB of the frame
data_out  output  WIDTH  completed frame, right-aligned, unused upper bits zero
data_valid  output  1  data_out holds an unconsumed frame
data_ready  input  1  consumer accepts data_out when data_valid && data_ready
overrun  output  1  sticky; a completed frame was dropped
busy  output  1  partial frame in progress (bit_count != 0)
bit_count  output  CW  bits accepted in the current frame

Behaviour:
- Reset (async): shift_reg=0, bit_count=0, data_out=0, data_valid=0, overrun=0, busy=0, latched length=WIDTH, latched mode=MSB-first.
- Priority per edge: reset > clear > normal operation. On clear: shift_reg=0, bit_count=0, data_valid=0, overrun=0; data_out retains its value, and any shift_en in that cycle is ignored.
- Frame start: when bit_count==0 and shift_en=1, frame_len (sanitised) and lsb_first are latched for the whole frame. Changing either input mid-frame has no effect.
- Bit accept, with k = bit_count before the edge:
  - MSB-first: shift_reg <= {shift_reg[WIDTH-2:0], serial_in}.
  - LSB-first: shift_reg[k] <= serial_in.
  - bit_count <= k+1.
- Completion: the edge that accepts bit number L (the latched length). On that edge:
  - The completed value goes to the output stage. MSB-first yields the last L shifted bits; LSB-first yields bits 0..L-1. Upper bits are zero in both modes.
  - bit_count <= 0 and shift_reg <= 0.
  - A shift_en on the very next cycle starts a new frame, so back-to-back frames incur no idle cycle.
- Latency: data_valid rises on the completion edge itself (registered output), i.e. data_out is visible in the cycle after the final bit is sampled.
- Handshake: data_out is stable while data_valid=1. A transfer occurs on an edge with data_valid && data_ready; data_valid then falls unless a new frame completes on the same edge.
- Completion while the holding register is free (data_valid=0, or data_ready=1 in the same cycle): load data_out, data_valid=1, no overrun.
- Completion while data_valid=1 && data_ready=0: the new frame is discarded, data_out and data_valid are unchanged, and overrun is set to 1. overrun stays set until clear or reset; later frames keep following the same rules.
- data_ready asserted while data_valid=0 has no effect.
- L=1 is legal: every accepted bit completes a frame. In that case bit_count stays 0 and busy stays 0.
- busy = (bit_count != 0), combinational from the register.

Test Plan:
- WIDTH=8, frame_len=8, lsb_first=0, data_ready=1; send bits 1,0,1,1,0,0,1,0 with shift_en every 3rd cycle -> data_out=0xB2, data_valid pulses for 1 cycle one cycle after the 8th bit, overrun=0.
- Same bit sequence with lsb_first=1 -> data_out=0x4D; then frame_len=5 with lsb_first=0 sending 1,0,0,1,1 -> data_out=0x13, upper 3 bits zero.
- data_ready=0 and two consecutive 8-bit frames 0xA5 then 0x3C -> data_out stays 0xA5, data_valid=1, overrun=1 after the 2nd completion; data_ready=1 for 1 cycle -> data_valid=0, overrun remains 1 until a clear pulse.
- Hold data_ready=0 after frame 0xA5, then raise data_ready on the exact completion edge of frame 0x3C -> 0xA5 transfers, data_out=0x3C, data_valid stays 1, overrun=0.
- Send 4 bits, pulse clear (then separately assert reset mid-frame) -> bit_count=0, busy=0, data_valid=0; the next 8 bits produce a clean frame with no residue from the aborted bits.
- Continuous shift_en=1 with frame_len=0 (treated as 8), plus frame_len changed to 3 mid-frame -> frames complete every 8 cycles with no gap; the length change takes effect only at the next frame start.
